// File: rtl/conv_kernel_scheduler_if.sv
// Handshake bundle between the layer controller / convolution engine side
// and conv_kernel_scheduler. The master modport is the scheduler's view;
// the slave modport is the environment (controller, engine, memories).
interface conv_kernel_scheduler_if #(
   parameter int KIDX_W = 4
);
   logic              start;
   logic              busy;
   logic [KIDX_W-1:0] kernel_sel;
   logic              conv_enable;
   logic              conv_done;
   logic              out_we;
   logic [KIDX_W-1:0] out_idx;
   logic              layer_done;
   logic              error;

   modport master (
      input  start,
      input  conv_done,
      output busy,
      output kernel_sel,
      output conv_enable,
      output out_we,
      output out_idx,
      output layer_done,
      output error
   );

   modport slave (
      output start,
      output conv_done,
      input  busy,
      input  kernel_sel,
      input  conv_enable,
      input  out_we,
      input  out_idx,
      input  layer_done,
      input  error
   );
endinterface

// File: rtl/conv_kernel_scheduler.sv
// conv_kernel_scheduler
// Walks the shared 8x8->6x6 convolution engine through NUM_KERNELS kernels
// for one image: LOAD (kernel read settles), RUN (engine enabled until
// done), STORE (one-cycle write strobe), then DONE pulses layer_done.
// All outputs come straight from registers.
// Optional feature: define CONV_SCHED_TIMEOUT_EN to build a RUN watchdog
// that aborts the pass with a sticky error after TIMEOUT_CYC cycles.
module conv_kernel_scheduler #(
   parameter int NUM_KERNELS = 4,
   parameter int KIDX_W      = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input logic                      clk,
   input logic                      rst_n,
   conv_kernel_scheduler_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_STORE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(NUM_KERNELS - 1);

   state_t            state_reg, state_next;
   logic              run_first_reg, run_first_next;
   logic              busy_reg, busy_next;
   logic              conv_enable_reg, conv_enable_next;
   logic              out_we_reg, out_we_next;
   logic              layer_done_reg, layer_done_next;
   logic [KIDX_W-1:0] kernel_sel_reg, kernel_sel_next;
   logic              start_accept;
   logic              done_taken;
   logic              timeout_hit;

   // The engine still shows done from the previous kernel in the first RUN
   // cycle, so conv_done only counts from the second RUN cycle onwards.
   assign start_accept = (state_reg == ST_IDLE) && bus.start;
   assign done_taken   = (state_reg == ST_RUN) && !run_first_reg && bus.conv_done;

`ifdef CONV_SCHED_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             error_reg, error_next;

   // tmo_cnt holds (RUN cycles elapsed - 1); the last allowed cycle is TIMEOUT_CYC
   assign timeout_hit = (state_reg == ST_RUN) && !done_taken &&
                        (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

   // Watchdog counter restarts from zero every time RUN is entered
   always_comb begin
      tmo_cnt_next = '0;
      if (state_reg == ST_RUN) begin
         tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
   end

   // Sticky error: set by a watchdog abort, cleared only by an accepted start
   always_comb begin
      error_next = error_reg;
      if (start_accept) begin
         error_next = 1'b0;
      end else if (timeout_hit) begin
         error_next = 1'b1;
      end
   end

   // Watchdog and error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_reg <= '0;
         error_reg   <= 1'b0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_next;
         error_reg   <= error_next;
      end
   end

   assign bus.error = error_reg;
`else
   // No watchdog: the comparison is never true, so RUN waits for conv_done forever
   assign timeout_hit = (TIMEOUT_CYC < 0);
   assign bus.error   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so nothing queues
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (done_taken) begin
               state_next = ST_STORE;
            end else if (timeout_hit) begin
               state_next = ST_DONE;
            end
         end
         ST_STORE: begin
            if (kernel_sel_reg == LAST_KIDX) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output logic: each registered output is decoded from the state being entered
   always_comb begin
      busy_next        = (state_next == ST_LOAD) || (state_next == ST_RUN) ||
                         (state_next == ST_STORE);
      conv_enable_next = (state_next == ST_RUN);
      out_we_next      = (state_next == ST_STORE);
      layer_done_next  = (state_next == ST_DONE);
      run_first_next   = (state_reg == ST_LOAD);
      kernel_sel_next  = kernel_sel_reg;
      if (start_accept) begin
         kernel_sel_next = '0;
      end else if ((state_reg == ST_STORE) && (state_next == ST_LOAD)) begin
         kernel_sel_next = kernel_sel_reg + 1'b1;
      end else if (state_next == ST_DONE) begin
         kernel_sel_next = '0;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg        <= 1'b0;
         conv_enable_reg <= 1'b0;
         out_we_reg      <= 1'b0;
         layer_done_reg  <= 1'b0;
         run_first_reg   <= 1'b0;
         kernel_sel_reg  <= '0;
      end else begin
         busy_reg        <= busy_next;
         conv_enable_reg <= conv_enable_next;
         out_we_reg      <= out_we_next;
         layer_done_reg  <= layer_done_next;
         run_first_reg   <= run_first_next;
         kernel_sel_reg  <= kernel_sel_next;
      end
   end

   // out_idx always mirrors kernel_sel, so it is valid whenever out_we fires
   assign bus.busy        = busy_reg;
   assign bus.conv_enable = conv_enable_reg;
   assign bus.out_we      = out_we_reg;
   assign bus.layer_done  = layer_done_reg;
   assign bus.kernel_sel  = kernel_sel_reg;
   assign bus.out_idx     = kernel_sel_reg;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Self-checking bench for conv_kernel_scheduler (NUM_KERNELS=4, TIMEOUT_CYC=8).
// Expected outputs come from a timeline model: a pass of N kernels with an
// engine needing R RUN cycles is LOAD, R x RUN, STORE per kernel, then DONE.
module tb_conv_kernel_scheduler;
   localparam int N   = 4;
   localparam int KW  = 4;
   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   conv_kernel_scheduler_if #(.KIDX_W(KW)) sif ();

   conv_kernel_scheduler #(
      .NUM_KERNELS (N),
      .KIDX_W      (KW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   // Engine model: done on the eng_r-th enabled cycle, or stuck high, or never.
   // noise_bit injects spurious done outside RUN and in the first RUN cycle.
   int eng_r     = 3;
   bit eng_stuck = 1'b0;
   bit eng_never = 1'b0;
   bit noise_bit = 1'b0;
   int run_cnt   = 0;

   always @(posedge clk) run_cnt <= sif.conv_enable ? run_cnt + 1 : 0;

   assign sif.conv_done = eng_never ? 1'b0 :
                          eng_stuck ? 1'b1 :
                          sif.conv_enable ? ((run_cnt + 1 >= eng_r) || (run_cnt == 0 && noise_bit)) :
                          noise_bit;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   typedef struct packed {
      logic          busy;
      logic          en;
      logic          we;
      logic          ld;
      logic          err;
      logic [KW-1:0] ksel;
   } obs_t;

   // Cycle c counts clock edges after the one that sampled start (c=1 is LOAD of kernel 0)
   function automatic obs_t model(int r, int c);
      obs_t o;
      int per, last, k, ph;
      o    = '0;
      per  = r + 2;
      last = N * per;
      if (c >= 1 && c <= last) begin
         k      = (c - 1) / per;
         ph     = (c - 1) % per;
         o.busy = 1'b1;
         o.en   = (ph >= 1) && (ph <= r);
         o.we   = (ph == r + 1);
         o.ksel = KW'(k);
      end else if (c == last + 1) begin
         o.ld = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.busy = sif.busy;
      o.en   = sif.conv_enable;
      o.we   = sif.out_we;
      o.ld   = sif.layer_done;
      o.err  = sif.error;
      o.ksel = sif.kernel_sel;
      return o;
   endfunction

   task automatic cmp_obs(input string tag, input int c, input obs_t e);
      obs_t a;
      a = observe();
      chk($sformatf("%s c%0d busy", tag, c), 32'(a.busy), 32'(e.busy));
      chk($sformatf("%s c%0d conv_enable", tag, c), 32'(a.en), 32'(e.en));
      chk($sformatf("%s c%0d out_we", tag, c), 32'(a.we), 32'(e.we));
      chk($sformatf("%s c%0d layer_done", tag, c), 32'(a.ld), 32'(e.ld));
      chk($sformatf("%s c%0d error", tag, c), 32'(a.err), 32'(e.err));
      chk($sformatf("%s c%0d kernel_sel", tag, c), 32'(a.ksel), 32'(e.ksel));
      if (e.we) chk($sformatf("%s c%0d out_idx", tag, c), 32'(sif.out_idx), 32'(e.ksel));
   endtask

   // One full pass: start pulse, cycle-by-cycle comparison, then one IDLE cycle
   task automatic run_pass(input string tag, input int r, input bit noise, input bit poke,
                           input int exp_ld, input int exp_we);
      int last, we_cnt, ld_at;
      obs_t zero;
      zero   = '0;
      last   = N * (r + 2);
      we_cnt = 0;
      ld_at  = -1;
      @(negedge clk);
      cmp_obs({tag, " idle"}, 0, zero);
      sif.start = 1'b1;
      for (int c = 1; c <= last + 1; c++) begin
         @(negedge clk);
         if (noise) noise_bit = 1'($urandom_range(0, 1));
         cmp_obs(tag, c, model(r, c));
         if (sif.out_we) we_cnt++;
         if (sif.layer_done && ld_at < 0) ld_at = c;
         sif.start = (poke && c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      cmp_obs({tag, " after"}, last + 2, zero);
      noise_bit = 1'b0;
      chk({tag, " layer_done cycle"}, 32'(ld_at), 32'(exp_ld));
      chk({tag, " out_we count"}, 32'(we_cnt), 32'(exp_we));
      $display("pass %s: r=%0d noise=%0d poke=%0d out_we=%0d layer_done@%0d", tag, r, noise, poke, we_cnt, ld_at);
   endtask

   typedef struct {
      int r;
      bit stuck;
      bit noise;
      bit poke;
      int exp_ld;
      int exp_we;
   } vec_t;

   vec_t vecs[5];

   initial begin
      obs_t zero;
      int   ld_q[$];
      int   waited;
      bit   found;
      zero = '0;

      // Table: layer_done cycle = 1 + 4*(R+2) counted from the start cycle
      vecs[0] = '{r: 3, stuck: 1'b0, noise: 1'b0, poke: 1'b0, exp_ld: 21, exp_we: 4};
      vecs[1] = '{r: 2, stuck: 1'b1, noise: 1'b0, poke: 1'b0, exp_ld: 17, exp_we: 4};
      vecs[2] = '{r: 5, stuck: 1'b0, noise: 1'b1, poke: 1'b1, exp_ld: 29, exp_we: 4};
      vecs[3] = '{r: 2, stuck: 1'b0, noise: 1'b1, poke: 1'b0, exp_ld: 17, exp_we: 4};
      vecs[4] = '{r: 7, stuck: 1'b0, noise: 1'b0, poke: 1'b1, exp_ld: 37, exp_we: 4};

      // Reset held with start high: everything stays zero
      sif.start = 1'b1;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmp_obs("reset", i, zero);
      end
      sif.start = 1'b0;
      rst_n     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmp_obs("post_reset", i, zero);
      end

      // Table-driven passes
      for (int v = 0; v < 5; v++) begin
         eng_r     = vecs[v].r;
         eng_stuck = vecs[v].stuck;
         if (eng_stuck) begin
            repeat (2) begin
               @(negedge clk);
               cmp_obs("stuck_idle", 0, zero);
            end
         end
         run_pass($sformatf("vec%0d", v), vecs[v].r, vecs[v].noise, vecs[v].poke,
                  vecs[v].exp_ld, vecs[v].exp_we);
         eng_stuck = 1'b0;
      end

      // Randomized passes
      for (int t = 0; t < 6; t++) begin
         int r;
         bit nz, pk;
         r  = int'($urandom_range(2, 6));
         nz = 1'($urandom_range(0, 1));
         pk = 1'($urandom_range(0, 1));
         eng_r = r;
         run_pass($sformatf("rand%0d", t), r, nz, pk, 1 + N * (r + 2), N);
      end

      // start held high: back-to-back passes, 22-cycle period (IDLE+20+DONE)
      eng_r = 3;
      @(negedge clk);
      sif.start = 1'b1;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         if (sif.layer_done) ld_q.push_back(c);
         if (c == 22) chk("b2b busy in idle c22", 32'(sif.busy), 32'd0);
         if (c == 23) chk("b2b busy in load c23", 32'(sif.busy), 32'd1);
         if (c == 23) chk("b2b kernel_sel c23", 32'(sif.kernel_sel), 32'd0);
      end
      sif.start = 1'b0;
      @(negedge clk);
      chk("b2b no queued pass", 32'(sif.busy), 32'd0);
      chk("b2b layer_done count", 32'(ld_q.size()), 32'd2);
      if (ld_q.size() == 2) begin
         chk("b2b first layer_done", 32'(ld_q[0]), 32'd21);
         chk("b2b second layer_done", 32'(ld_q[1]), 32'd43);
      end
      $display("pass b2b: layer_done pulses=%0d", ld_q.size());

      // Reset during RUN of kernel 2
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      waited = 0;
      found  = 1'b0;
      while (!found && waited < 60) begin
         @(negedge clk);
         waited++;
         if (sif.kernel_sel == KW'(2) && sif.conv_enable) found = 1'b1;
      end
      chk("midreset reached kernel2 run", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1 cmp_obs("midreset async", 0, zero);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         cmp_obs("midreset held", i, zero);
      end
      rst_n = 1'b1;
      $display("pass midreset: aborted at kernel 2");
      run_pass("after_midreset", 3, 1'b0, 1'b0, 21, 4);

`ifdef CONV_SCHED_TIMEOUT_EN
      // Watchdog: engine silent, abort after 8 RUN cycles of kernel 0
      eng_never = 1'b1;
      @(negedge clk);
      sif.start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         sif.start = 1'b0;
         chk($sformatf("tmo c%0d out_we", c), 32'(sif.out_we), 32'd0);
         chk($sformatf("tmo c%0d conv_enable", c), 32'(sif.conv_enable), 32'((c >= 2 && c <= 9) ? 1 : 0));
         chk($sformatf("tmo c%0d layer_done", c), 32'(sif.layer_done), 32'(c == 10 ? 1 : 0));
         chk($sformatf("tmo c%0d error", c), 32'(sif.error), 32'(c >= 10 ? 1 : 0));
         chk($sformatf("tmo c%0d kernel_sel", c), 32'(sif.kernel_sel), 32'd0);
      end
      eng_never = 1'b0;
      eng_r     = 3;
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      chk("tmo error cleared by start", 32'(sif.error), 32'd0);
      chk("tmo restart busy", 32'(sif.busy), 32'd1);
      waited = 0;
      while (!sif.layer_done && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      chk("tmo recovery pass completes", 32'(sif.layer_done), 32'd1);
      chk("tmo recovery error", 32'(sif.error), 32'd0);
      $display("pass timeout: error raised and cleared");
`else
      // No watchdog: RUN waits indefinitely, error stays 0
      eng_never = 1'b1;
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      found = 1'b0;
      for (int c = 2; c <= 30; c++) begin
         @(negedge clk);
         if (sif.layer_done || sif.out_we || sif.error) found = 1'b1;
      end
      chk("no_tmo stuck in run enable", 32'(sif.conv_enable), 32'd1);
      chk("no_tmo busy", 32'(sif.busy), 32'd1);
      chk("no_tmo no done/we/error", 32'(found), 32'd0);
      chk("no_tmo kernel_sel", 32'(sif.kernel_sel), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      eng_never = 1'b0;
      $display("pass no_timeout: waited 30 cycles in RUN");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "simulation time limit");
   end
endmodule
